// File: rtl/led_pattern_seq.sv
// LED bank pattern sequencer: steps an off/blink/chase/breathe pattern on each
// upstream tick strobe. Breathe is rendered through a free-running PWM counter.
module led_pattern_seq #(
  parameter int NUM_LEDS  = 4,
  parameter int PWM_WIDTH = 8,
  parameter int DUTY_STEP = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_tick,
  input  logic [1:0]          i_mode,
  input  logic                i_mode_load,
  output logic [NUM_LEDS-1:0] o_led,
  output logic [1:0]          o_mode,
  output logic                o_wrap
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam int IDX_W = (NUM_LEDS > 2) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PWM_WIDTH-1:0] DUTY_MAX = '1;
  localparam logic [PWM_WIDTH:0]   STEP     = (PWM_WIDTH+1)'(DUTY_STEP);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_LEDS - 1);

  mode_t                mode, mode_nx;
  logic                 phase, phase_nx;
  logic [IDX_W-1:0]     index, index_nx;
  logic [PWM_WIDTH-1:0] duty, duty_nx;
  logic                 down, down_nx;
  logic [PWM_WIDTH-1:0] pwm, pwm_nx;
  logic [NUM_LEDS-1:0]  led, led_nx;
  logic                 wrap, wrap_nx;
  logic [PWM_WIDTH:0]   sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode  <= MODE_OFF;
      phase <= 1'b0;
      index <= '0;
      duty  <= '0;
      down  <= 1'b0;
      pwm   <= '0;
      led   <= '0;
      wrap  <= 1'b0;
    end else begin
      mode  <= mode_nx;
      phase <= phase_nx;
      index <= index_nx;
      duty  <= duty_nx;
      down  <= down_nx;
      pwm   <= pwm_nx;
      led   <= led_nx;
      wrap  <= wrap_nx;
    end
  end

  // A load restarts the selected pattern and swallows any coincident tick;
  // the extra guard bit on sum lets the breathe ramp saturate instead of wrapping.
  always_comb begin
    mode_nx  = mode;
    phase_nx = phase;
    index_nx = index;
    duty_nx  = duty;
    down_nx  = down;
    pwm_nx   = pwm + 1'b1;
    wrap_nx  = 1'b0;
    led_nx   = '0;
    sum      = {1'b0, duty} + STEP;

    if (i_mode_load) begin
      mode_nx  = mode_t'(i_mode);
      phase_nx = 1'b0;
      index_nx = '0;
      duty_nx  = '0;
      down_nx  = 1'b0;
    end else if (i_tick) begin
      case (mode)
        MODE_OFF: ;
        MODE_BLINK: begin
          phase_nx = ~phase;
          wrap_nx  = phase;
        end
        MODE_CHASE: begin
          if (index == LAST_IDX) begin
            index_nx = '0;
            wrap_nx  = 1'b1;
          end else begin
            index_nx = index + 1'b1;
          end
        end
        MODE_BREATHE: begin
          if (!down) begin
            if (sum >= {1'b0, DUTY_MAX}) begin
              duty_nx = DUTY_MAX;
              down_nx = 1'b1;
            end else begin
              duty_nx = sum[PWM_WIDTH-1:0];
            end
          end else if ({1'b0, duty} <= STEP) begin
            duty_nx = '0;
            down_nx = 1'b0;
            wrap_nx = 1'b1;
          end else begin
            duty_nx = duty - STEP[PWM_WIDTH-1:0];
          end
        end
      endcase
    end

    case (mode_nx)
      MODE_OFF:     led_nx = '0;
      MODE_BLINK:   led_nx = {NUM_LEDS{phase_nx}};
      MODE_CHASE:   led_nx = NUM_LEDS'(1) << index_nx;
      MODE_BREATHE: led_nx = {NUM_LEDS{pwm_nx < duty_nx}};
    endcase
  end

  assign o_led  = led;
  assign o_mode = mode;
  assign o_wrap = wrap;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: fixed vector table, hand-written breathe/reset
// sequences and a randomized run against a tick-counting reference model.
module tb_led_pattern_seq;

  localparam int N      = 4;
  localparam int PW     = 8;
  localparam int STEP   = 16;
  localparam int STEP_B = 100;
  localparam int MAXD   = (1 << PW) - 1;

  typedef struct {
    logic         tick;
    logic         load;
    logic [1:0]   mode;
    logic [N-1:0] exp_led;
    logic [1:0]   exp_mode;
    logic         exp_wrap;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic         mode_load = 1'b0;
  logic [1:0]   mode_in = 2'd0;
  logic [N-1:0] led, led_b;
  logic [1:0]   mode, mode_b;
  logic         wrap, wrap_b;

  int total = 0;
  int bad = 0;

  logic [1:0]   m_mode;
  int           m_ticks, m_duty, m_pwm;
  bit           m_up, m_wrap;
  logic [N-1:0] m_led;

  vec_t vecs[$];
  int   exp_b[6] = '{100, 200, 255, 155, 55, 0};

  always #5 clk = ~clk;

  led_pattern_seq #(.NUM_LEDS(N), .PWM_WIDTH(PW), .DUTY_STEP(STEP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_mode(mode_in),
    .i_mode_load(mode_load), .o_led(led), .o_mode(mode), .o_wrap(wrap)
  );

  led_pattern_seq #(.NUM_LEDS(N), .PWM_WIDTH(PW), .DUTY_STEP(STEP_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_mode(mode_in),
    .i_mode_load(mode_load), .o_led(led_b), .o_mode(mode_b), .o_wrap(wrap_b)
  );

  task automatic modelReset();
    m_mode = 2'd0; m_ticks = 0; m_duty = 0; m_pwm = 0;
    m_up = 1'b1; m_wrap = 1'b0; m_led = '0;
  endtask

  // Model keeps a tick count since load and derives blink/chase from it;
  // breathe is a saturating integer ramp.
  task automatic modelUpdate(input logic t, input logic l, input logic [1:0] m);
    m_pwm  = (m_pwm + 1) % (MAXD + 1);
    m_wrap = 1'b0;
    if (l) begin
      m_mode = m; m_ticks = 0; m_duty = 0; m_up = 1'b1;
    end else if (t && m_mode != 2'd0) begin
      m_ticks++;
      if (m_mode == 2'd1) m_wrap = (m_ticks % 2 == 0);
      if (m_mode == 2'd2) m_wrap = (m_ticks % N == 0);
      if (m_mode == 2'd3) begin
        if (m_up) begin
          m_duty = (m_duty + STEP > MAXD) ? MAXD : m_duty + STEP;
          if (m_duty == MAXD) m_up = 1'b0;
        end else begin
          m_duty = (m_duty - STEP < 0) ? 0 : m_duty - STEP;
          if (m_duty == 0) begin m_up = 1'b1; m_wrap = 1'b1; end
        end
      end
    end
    case (m_mode)
      2'd0: m_led = '0;
      2'd1: m_led = (m_ticks % 2 == 1) ? '1 : '0;
      2'd2: m_led = N'(1) << (m_ticks % N);
      default: m_led = (m_pwm < m_duty) ? '1 : '0;
    endcase
  endtask

  task automatic applyStimulus(input logic t, input logic l, input logic [1:0] m);
    tick = t; mode_load = l; mode_in = m;
    @(posedge clk);
    modelUpdate(t, l, m);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] el,
                             input logic [1:0] em, input logic ew);
    total++;
    if (led !== el || mode !== em || wrap !== ew) begin
      bad++;
      $display("[TB] FAIL %s: got led=%h mode=%0d wrap=%b, want led=%h mode=%0d wrap=%b",
               name, led, mode, wrap, el, em, ew);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_led, m_mode, m_wrap);
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int c, cb;
    modelReset();

    vecs.push_back('{1'b0, 1'b1, 2'd1, 4'h0, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'hF, 2'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 4'hF, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h0, 2'd1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'hF, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h0, 2'd1, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 4'h1, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h2, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h4, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h8, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h1, 2'd2, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 4'h1, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h2, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h4, 2'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h8, 2'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'd0, 4'h8, 2'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 4'h1, 2'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 4'h0, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'h0, 2'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'd1, 4'h0, 2'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'd0, 4'hF, 2'd1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 4'h0, 2'd0, 1'b0});

    #12;
    checkOutput("reset_state", 4'h0, 2'd0, 1'b0);
    rst_n = 1'b1;
    modelReset();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].tick, vecs[i].load, vecs[i].mode);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_mode, vecs[i].exp_wrap);
    end

    applyStimulus(1'b0, 1'b1, 2'd2);
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0);
    checkOutput("chase_idx2", 4'h4, 2'd2, 1'b0);
    tick = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset", 4'h0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd0);
      checkOutput("post_reset_tick", 4'h0, 2'd0, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, 2'd3);
    checkModel("breathe_load");
    checkValue("mode_b", int'(mode_b), 3);
    for (int k = 1; k <= 32; k++) begin
      applyStimulus(1'b1, 1'b0, 2'd0);
      checkModel("breathe_tick");
      if (k <= 7) checkValue("wrap_b", int'(wrap_b), (k == 6) ? 1 : 0);
      if (k <= 6 || k == 16 || k == 32) begin
        c = 0; cb = 0;
        for (int j = 0; j < 256; j++) begin
          applyStimulus(1'b0, 1'b0, 2'd0);
          checkModel("breathe_pwm");
          if (led == '1) c++;
          if (led_b == '1) cb++;
        end
        if (k == 4) checkValue("duty64_count", c, 64);
        else if (k == 16) checkValue("duty255_count", c, 255);
        else if (k == 32) checkValue("duty0_count", c, 0);
        else checkValue("duty_count", c, m_duty);
        if (k <= 6) checkValue("step100_count", cb, exp_b[k-1]);
      end
    end

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(2) == 0), ($urandom_range(19) == 0),
                    2'($urandom_range(3)));
      checkModel("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
